// File: rtl/tinyriscv_pkg.sv
// Shared bus widths, gpio_seq register offsets and sequencer state encoding.
package tinyriscv_pkg;

  localparam int MemBus  = 32;
  localparam int InstBus = 32;

  localparam logic [5:0] REG_CTRL = 6'h00;
  localparam logic [5:0] REG_STAT = 6'h04;
  localparam logic [5:0] REG_DIV  = 6'h08;
  localparam logic [5:0] REG_PAT0 = 6'h10;
  localparam logic [5:0] REG_PAT7 = 6'h2C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } seq_state_e;

  function automatic logic is_pat(input logic [5:0] off);
    return (off >= REG_PAT0) && (off <= REG_PAT7) && (off[1:0] == 2'b00);
  endfunction

  function automatic logic [2:0] pat_sel(input logic [5:0] off);
    logic [5:0] rel;
    rel = off - REG_PAT0;
    return rel[4:2];
  endfunction

endpackage

// File: rtl/gpio_seq.sv
// GPIO pattern sequencer: plays PAT[0..LEN-1] into the GPIO data register at a
// programmable interval, sharing the GPIO slave port with the CPU (CPU first).
module gpio_seq
  import tinyriscv_pkg::*;
#(
  parameter logic [InstBus-1:0] GPIO_DATA_ADDR = 32'h4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [InstBus-1:0] addr_i,
  input  logic [MemBus-1:0]  data_i,
  output logic [MemBus-1:0]  data_o,
  input  logic               cpu_gpio_we_i,
  input  logic [InstBus-1:0] cpu_gpio_addr_i,
  input  logic [MemBus-1:0]  cpu_gpio_data_i,
  output logic               gpio_we_o,
  output logic [InstBus-1:0] gpio_addr_o,
  output logic [MemBus-1:0]  gpio_data_o,
  output logic               busy_o,
  output logic               done_o
);

  seq_state_e        state, state_nxt;
  logic [2:0]        idx, idx_nxt;
  logic [MemBus-1:0] cnt, cnt_nxt;
  logic              done, done_nxt;
  logic              loop;
  logic [2:0]        len;
  logic [MemBus-1:0] div;
  logic [MemBus-1:0] pat [8];

  logic [5:0]        offset;
  logic              ctrl_wr, stop_wr, start_wr, grant, last;
  logic              unused_addr;

  assign offset      = addr_i[5:0];
  assign unused_addr = ^addr_i[InstBus-1:6];
  assign ctrl_wr     = we_i && (offset == REG_CTRL);
  // stop wins over a simultaneous start
  assign stop_wr     = ctrl_wr && data_i[2];
  assign start_wr    = ctrl_wr && data_i[0] && !data_i[2];
  assign grant       = !cpu_gpio_we_i;
  assign last        = (idx == len);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      loop <= 1'b0;
      len  <= 3'd0;
      div  <= '0;
      for (int i = 0; i < 8; i++) begin
        pat[i] <= '0;
      end
    end else if (we_i) begin
      case (offset)
        REG_CTRL: begin
          loop <= data_i[1];
          len  <= data_i[6:4];
        end
        REG_DIV: div <= data_i;
        default: begin
          if (is_pat(offset)) begin
            pat[pat_sel(offset)] <= data_i;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
      idx   <= 3'd0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    done_nxt  = done;
    if (stop_wr) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_wr) begin
            state_nxt = ST_LOAD;
            idx_nxt   = 3'd0;
            done_nxt  = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (!grant) begin
            state_nxt = ST_LOAD;
          end else if (last && !loop) begin
            // final write of a one-shot run: no trailing interval
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = last ? 3'd0 : idx + 3'd1;
            if (div == '0) begin
              state_nxt = ST_LOAD;
            end else begin
              cnt_nxt   = div - MemBus'(1);
              state_nxt = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state_nxt = ST_LOAD;
          end else begin
            cnt_nxt = cnt - MemBus'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    data_o = '0;
    if (!rst_ni) begin
      data_o = '0;
    end else begin
      case (offset)
        REG_CTRL: begin
          data_o[1]   = loop;
          data_o[6:4] = len;
        end
        REG_STAT: begin
          data_o[0]   = busy_o;
          data_o[1]   = done;
          data_o[6:4] = idx;
        end
        REG_DIV: data_o = div;
        default: begin
          if (is_pat(offset)) begin
            data_o = pat[pat_sel(offset)];
          end else begin
            data_o = '0;
          end
        end
      endcase
    end
  end

  // GPIO port arbiter: CPU has fixed priority, reads pass through when idle
  always_comb begin
    gpio_we_o   = 1'b0;
    gpio_addr_o = cpu_gpio_addr_i;
    gpio_data_o = cpu_gpio_data_i;
    if (cpu_gpio_we_i) begin
      gpio_we_o = 1'b1;
    end else if (state == ST_LOAD) begin
      gpio_we_o   = 1'b1;
      gpio_addr_o = GPIO_DATA_ADDR;
      gpio_data_o = pat[idx];
    end else begin
      gpio_we_o = 1'b0;
    end
  end

  assign busy_o = (state != ST_IDLE);
  assign done_o = done;

endmodule

// File: tb/tb_gpio_seq.sv
// Randomised bench for gpio_seq; expected write schedules come from a timing model
// (pending write slips while the CPU owns the port, then next = grant + DIV + 1).
module tb_gpio_seq;
  import tinyriscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] data_i = 32'd0;
  logic [31:0] data_o;
  logic        cpu_gpio_we_i = 1'b0;
  logic [31:0] cpu_gpio_addr_i = 32'd0;
  logic [31:0] cpu_gpio_data_i = 32'd0;
  logic        gpio_we_o;
  logic [31:0] gpio_addr_o;
  logic [31:0] gpio_data_o;
  logic        busy_o, done_o;

  gpio_seq #(.GPIO_DATA_ADDR(32'h4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .cpu_gpio_we_i(cpu_gpio_we_i), .cpu_gpio_addr_i(cpu_gpio_addr_i),
    .cpu_gpio_data_i(cpu_gpio_data_i), .gpio_we_o(gpio_we_o), .gpio_addr_o(gpio_addr_o),
    .gpio_data_o(gpio_data_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc;
  bit          cpu_hist [0:1023];
  int          obs_c[$];
  logic [31:0] obs_v[$];
  int          exp_c[$];
  logic [31:0] exp_v[$];
  logic [31:0] pats [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we_i = 1'b1; addr_i = a; data_i = d;
    step();
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr_i = a;
    #1;
    d = data_o;
  endtask

  // One bus cycle per iteration; records sequencer writes, checks CPU pass-through.
  task automatic run(input int n, input int pct, input int force_at);
    for (int i = 0; i < n; i++) begin
      cyc++;
      cpu_gpio_we_i   = (cyc == force_at) || ($urandom_range(99) < pct);
      cpu_gpio_addr_i = $urandom;
      cpu_gpio_data_i = $urandom;
      cpu_hist[cyc]   = cpu_gpio_we_i;
      #2;
      if (cpu_gpio_we_i) begin
        n_tests++;
        if (gpio_we_o !== 1'b1 || gpio_addr_o !== cpu_gpio_addr_i || gpio_data_o !== cpu_gpio_data_i) begin
          n_fail++;
          $display("FAIL cpu_passthru cyc=%0d: we=%b addr=%h data=%h, expected we=1 addr=%h data=%h",
                   cyc, gpio_we_o, gpio_addr_o, gpio_data_o, cpu_gpio_addr_i, cpu_gpio_data_i);
        end
      end else if (gpio_we_o === 1'b1) begin
        obs_c.push_back(cyc);
        obs_v.push_back(gpio_data_o);
        n_tests++;
        if (gpio_addr_o !== 32'h4) begin
          n_fail++;
          $display("FAIL seq_addr cyc=%0d: got %h expected 00000004", cyc, gpio_addr_o);
        end
      end
      step();
    end
    cpu_gpio_we_i = 1'b0;
  endtask

  task automatic ctrl_in_run(input logic [31:0] d);
    cyc++;
    cpu_hist[cyc] = 1'b0;
    we_i = 1'b1; addr_i = {26'd0, REG_CTRL}; data_i = d;
    #2;
    if (gpio_we_o === 1'b1) begin
      obs_c.push_back(cyc);
      obs_v.push_back(gpio_data_o);
    end
    step();
    we_i = 1'b0;
  endtask

  // Reference timing model built from the write-spacing rules.
  task automatic model(input int count, input int d, input bit loop, input int horizon);
    int p, k;
    exp_c.delete(); exp_v.delete();
    p = 1; k = 0;
    while (1) begin
      while (p <= horizon && cpu_hist[p]) p++;
      if (p > horizon) break;
      exp_c.push_back(p);
      exp_v.push_back(pats[k % count]);
      k++;
      if (!loop && k == count) break;
      p += d + 1;
    end
  endtask

  task automatic configure(input int count, input int d, input bit loop);
    for (int i = 0; i < 8; i++) wr({26'd0, REG_PAT0} + 32'(4 * i), pats[i]);
    wr({26'd0, REG_DIV}, 32'(d));
    wr({26'd0, REG_CTRL}, 32'((count - 1) << 4) | (loop ? 32'h2 : 32'h0));
  endtask

  task automatic start_seq(input logic [31:0] ctrl);
    cyc = 0;
    cpu_hist[0] = 1'b0;
    obs_c.delete(); obs_v.delete();
    wr({26'd0, REG_CTRL}, ctrl);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] regs [4];
    regs = '{32'h00, 32'h04, 32'h08, 32'h10};
    rst_ni = 1'b0;
    repeat (3) step();
    rst_ni = 1'b1;
    cpu_gpio_addr_i = 32'hA5A5_0010;
    step();
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || gpio_we_o !== 1'b0 || gpio_addr_o !== 32'hA5A5_0010) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b we=%b addr=%h, expected 0 0 0 a5a50010",
               busy_o, done_o, gpio_we_o, gpio_addr_o);
    end
    foreach (regs[i]) begin
      rd(regs[i], v);
      n_tests++;
      if (v !== 32'd0) begin n_fail++; $display("FAIL reset_reg %h: got %h expected 0", regs[i], v); end
    end
  endtask

  task automatic test_regs();
    logic [31:0] v, dv, pv;
    dv = $urandom; pv = $urandom;
    wr(32'h08, dv);
    wr(32'h1C, pv);
    wr(32'h2C, ~pv);
    wr(32'h00, 32'hFFFF_FFFA);
    wr(32'h04, 32'hFFFF_FFFF);
    wr(32'h0C, 32'hFFFF_FFFF);
    rd(32'h08, v); n_tests++;
    if (v !== dv) begin n_fail++; $display("FAIL reg_div: got %h expected %h", v, dv); end
    rd(32'h1C, v); n_tests++;
    if (v !== pv) begin n_fail++; $display("FAIL reg_pat3: got %h expected %h", v, pv); end
    rd(32'h2C, v); n_tests++;
    if (v !== ~pv) begin n_fail++; $display("FAIL reg_pat7: got %h expected %h", v, ~pv); end
    rd(32'h00, v); n_tests++;
    if (v !== 32'h72) begin n_fail++; $display("FAIL reg_ctrl: got %h expected 00000072", v); end
    rd(32'h04, v); n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reg_stat_ro: got %h expected 0", v); end
    rd(32'h0C, v); n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reg_unmapped: got %h expected 0", v); end
    wr(32'h00, 32'h0);
  endtask

  task automatic test_oneshot();
    pats = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    configure(3, 3, 1'b0);
    start_seq(32'h21);
    n_tests++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL oneshot_busy: got %b expected 1", busy_o); end
    run(9, 0, -1);
    exp_c = '{1, 5, 9}; exp_v = '{32'd1, 32'd2, 32'd3};
    n_tests++;
    if (obs_c.size() != exp_c.size()) begin n_fail++; $display("FAIL oneshot_count: got %0d expected %0d", obs_c.size(), exp_c.size()); end
    for (int i = 0; i < exp_c.size() && i < obs_c.size(); i++) begin
      n_tests++;
      if (obs_c[i] != exp_c[i] || obs_v[i] !== exp_v[i]) begin
        n_fail++; $display("FAIL oneshot_write%0d: got cyc %0d val %h expected cyc %0d val %h", i, obs_c[i], obs_v[i], exp_c[i], exp_v[i]);
      end
    end
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b1) begin n_fail++; $display("FAIL oneshot_done: busy=%b done=%b expected 0 1", busy_o, done_o); end
  endtask

  task automatic test_start_stop();
    wr(32'h00, 32'h25);
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b1) begin n_fail++; $display("FAIL startstop_idle: busy=%b done=%b expected 0 1", busy_o, done_o); end
    start_seq(32'h20);
    run(4, 0, -1);
    n_tests++;
    if (obs_c.size() != 0) begin n_fail++; $display("FAIL startstop_writes: got %0d expected 0", obs_c.size()); end
  endtask

  task automatic test_stall();
    configure(3, 3, 1'b0);
    start_seq(32'h21);
    run(12, 0, 1);
    exp_c = '{2, 6, 10}; exp_v = '{32'd1, 32'd2, 32'd3};
    n_tests++;
    if (obs_c.size() != exp_c.size()) begin n_fail++; $display("FAIL stall_count: got %0d expected %0d", obs_c.size(), exp_c.size()); end
    for (int i = 0; i < exp_c.size() && i < obs_c.size(); i++) begin
      n_tests++;
      if (obs_c[i] != exp_c[i] || obs_v[i] !== exp_v[i]) begin
        n_fail++; $display("FAIL stall_write%0d: got cyc %0d val %h expected cyc %0d val %h", i, obs_c[i], obs_v[i], exp_c[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_loop_stop();
    configure(3, 3, 1'b1);
    start_seq(32'h23);
    run(13, 0, -1);
    exp_c = '{1, 5, 9, 13}; exp_v = '{32'd1, 32'd2, 32'd3, 32'd1};
    n_tests++;
    if (obs_c.size() != exp_c.size()) begin n_fail++; $display("FAIL loop_count: got %0d expected %0d", obs_c.size(), exp_c.size()); end
    for (int i = 0; i < exp_c.size() && i < obs_c.size(); i++) begin
      n_tests++;
      if (obs_c[i] != exp_c[i] || obs_v[i] !== exp_v[i]) begin
        n_fail++; $display("FAIL loop_write%0d: got cyc %0d val %h expected cyc %0d val %h", i, obs_c[i], obs_v[i], exp_c[i], exp_v[i]);
      end
    end
    ctrl_in_run(32'h4);
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL loop_stop: busy=%b done=%b expected 0 0", busy_o, done_o); end
    obs_c.delete();
    run(6, 0, -1);
    n_tests++;
    if (obs_c.size() != 0) begin n_fail++; $display("FAIL loop_after_stop: got %0d writes expected 0", obs_c.size()); end
  endtask

  task automatic test_start_busy();
    configure(3, 3, 1'b0);
    start_seq(32'h21);
    run(2, 0, -1);
    ctrl_in_run(32'h21);
    run(7, 0, -1);
    exp_c = '{1, 5, 9}; exp_v = '{32'd1, 32'd2, 32'd3};
    n_tests++;
    if (obs_c.size() != exp_c.size()) begin n_fail++; $display("FAIL startbusy_count: got %0d expected %0d", obs_c.size(), exp_c.size()); end
    for (int i = 0; i < exp_c.size() && i < obs_c.size(); i++) begin
      n_tests++;
      if (obs_c[i] != exp_c[i] || obs_v[i] !== exp_v[i]) begin
        n_fail++; $display("FAIL startbusy_write%0d: got cyc %0d val %h expected cyc %0d val %h", i, obs_c[i], obs_v[i], exp_c[i], exp_v[i]);
      end
    end
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b1) begin n_fail++; $display("FAIL startbusy_done: busy=%b done=%b expected 0 1", busy_o, done_o); end
  endtask

  task automatic test_back_to_back();
    foreach (pats[i]) pats[i] = $urandom;
    configure(8, 0, 1'b0);
    start_seq(32'h71);
    run(10, 0, -1);
    model(8, 0, 1'b0, 10);
    n_tests++;
    if (obs_c.size() != 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", obs_c.size()); end
    for (int i = 0; i < exp_c.size() && i < obs_c.size(); i++) begin
      n_tests++;
      if (obs_c[i] != i + 1 || obs_v[i] !== exp_v[i]) begin
        n_fail++; $display("FAIL b2b_write%0d: got cyc %0d val %h expected cyc %0d val %h", i, obs_c[i], obs_v[i], i + 1, exp_v[i]);
      end
    end
  endtask

  task automatic test_random();
    int count, d, horizon;
    bit loop;
    for (int t = 0; t < 6; t++) begin
      count = $urandom_range(8, 1);
      d     = $urandom_range(4);
      loop  = (t >= 4);
      horizon = loop ? 50 : count * (d + 1) + 40;
      foreach (pats[i]) pats[i] = $urandom;
      configure(count, d, loop);
      start_seq(32'((count - 1) << 4) | (loop ? 32'h3 : 32'h1));
      run(horizon, 25, -1);
      model(count, d, loop, horizon);
      n_tests++;
      if (obs_c.size() != exp_c.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", t, obs_c.size(), exp_c.size()); end
      for (int i = 0; i < exp_c.size() && i < obs_c.size(); i++) begin
        n_tests++;
        if (obs_c[i] != exp_c[i] || obs_v[i] !== exp_v[i]) begin
          n_fail++; $display("FAIL rand%0d_write%0d: got cyc %0d val %h expected cyc %0d val %h", t, i, obs_c[i], obs_v[i], exp_c[i], exp_v[i]);
        end
      end
      if (loop) begin
        ctrl_in_run(32'h4);
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rand%0d_stop: busy=%b expected 0", t, busy_o); end
      end else if (exp_c.size() == count) begin
        n_tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b1) begin n_fail++; $display("FAIL rand%0d_done: busy=%b done=%b expected 0 1", t, busy_o, done_o); end
      end
    end
  endtask

  task automatic test_reset_wait();
    logic [31:0] v;
    logic [31:0] regs [6];
    regs = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14, 32'h18};
    pats = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    configure(3, 3, 1'b0);
    start_seq(32'h21);
    run(1, 0, -1);
    rst_ni = 1'b0;
    rd(32'h08, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL rstwait_data_low: got %h expected 0", v); end
    step();
    rst_ni = 1'b1;
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL rstwait_busy: busy=%b done=%b expected 0 0", busy_o, done_o); end
    foreach (regs[i]) begin
      rd(regs[i], v);
      n_tests++;
      if (v !== 32'd0) begin n_fail++; $display("FAIL rstwait_reg %h: got %h expected 0", regs[i], v); end
    end
    obs_c.delete();
    run(12, 0, -1);
    n_tests++;
    if (obs_c.size() != 0) begin n_fail++; $display("FAIL rstwait_writes: got %0d expected 0", obs_c.size()); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_oneshot();
    test_start_stop();
    test_stall();
    test_loop_stop();
    test_start_busy();
    test_back_to_back();
    test_random();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_seq.md
GPIO_SEQ -- requirements
Module: gpio_seq

Interface
REQ-001 SHALL have parameter GPIO_DATA_ADDR, default 32'h4, the address the sequencer writes to reach the GPIO data register.
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_ni, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port we_i, input, 1, config-register write strobe.
REQ-005 SHALL have port addr_i, input, InstBus, config-register address; addr_i[5:0] is decoded.
REQ-006 SHALL have port data_i, input, MemBus, config write data.
REQ-007 SHALL have port data_o, output, MemBus, config read data.
REQ-008 SHALL have ports cpu_gpio_we_i (1), cpu_gpio_addr_i (InstBus) and cpu_gpio_data_i (MemBus), inputs, the CPU request to GPIO.
REQ-009 SHALL have ports gpio_we_o (1), gpio_addr_o (InstBus) and gpio_data_o (MemBus), outputs, the arbitrated GPIO slave port.
REQ-010 SHALL have ports busy_o and done_o, outputs, 1 each, mirroring the STAT bits.

Function
REQ-011 Registers SHALL be:
- CTRL 0x00: bit0 start (write-1 pulse, reads 0); bit1 loop; bit2 stop (write-1 pulse, reads 0); [6:4] LEN-1.
- STAT 0x04, read-only: bit0 busy; bit1 done; [6:4] current index.
- DIV 0x08: interval count, 32 bit.
- PAT0..PAT7 0x10..0x2C: MemBus-wide patterns.
- Any other offset reads 0 and ignores writes.
REQ-012 data_o SHALL be combinational from addr_i[5:0], and SHALL be 0 while rst_ni is low.
REQ-013 FSM states SHALL be IDLE, LOAD and WAIT.
REQ-014 IDLE: a CTRL write with start=1 and stop=0 SHALL move to LOAD, set idx=0 and clear done.
REQ-015 LOAD SHALL request a write of PAT[idx] to GPIO_DATA_ADDR, and the request SHALL be granted only when cpu_gpio_we_i is 0.
REQ-016 LOAD not granted: the FSM SHALL hold in LOAD with no index or counter change (stall).
REQ-017 LOAD granted with DIV==0: the FSM SHALL advance idx and stay in LOAD, so writes are back-to-back.
REQ-018 LOAD granted with DIV!=0: the FSM SHALL load cnt=DIV-1, advance idx and enter WAIT.
REQ-019 WAIT SHALL decrement cnt each cycle and go to LOAD in the cycle after cnt==0, giving an uncontended write spacing of exactly DIV+1 cycles.
REQ-020 Index advance at idx==LEN-1:
- loop=1: idx wraps to 0.
- loop=0: the FSM goes to IDLE and sets done; no WAIT follows the last write.
REQ-021 A CTRL write with stop=1 in any state SHALL force IDLE next cycle and leave done unchanged.
- If stop=1 and start=1 in the same write, stop wins.
REQ-022 start while busy SHALL be ignored; the other CTRL fields still update.
REQ-023 DIV and PAT writes while busy SHALL take effect at the next LOAD or next cnt load.
REQ-024 Arbitration:
- If cpu_gpio_we_i=1, the gpio_* outputs SHALL equal the cpu_gpio_* inputs (CPU has fixed priority).
- Otherwise, in LOAD, gpio_we_o=1, gpio_addr_o=GPIO_DATA_ADDR and gpio_data_o=PAT[idx].
- Otherwise, gpio_we_o=0 and gpio_addr_o/gpio_data_o pass the CPU values, so CPU reads work.
REQ-025 Arbitration outputs SHALL be combinational; sequencer write latency from the start write SHALL be 1 cycle (LOAD is entered in the next cycle).
REQ-026 busy SHALL be 1 exactly when state!=IDLE.

Reset
REQ-027 With rst_ni low at a clock edge, the block SHALL set state=IDLE, idx=0, cnt=0, CTRL=0, DIV=0, all PAT=0 and done=0, with busy_o=0, done_o=0 and gpio_we_o=0 (absent CPU request); reset mid-sequence SHALL abort with no further sequencer writes.

Structure
REQ-028 Register offsets and the state enum SHALL live in tinyriscv_pkg, next to MemBus and InstBus.
REQ-029 No sub-module is needed; the arbiter SHALL be an inline always_comb block, and the estimated size is about 200 lines.

Verification
REQ-030 Set LEN-1=2, DIV=3 and PAT0..2=1,2,3, then start -> GPIO writes 1,2,3 at cycles t+1, t+5, t+9; done=1 and busy=0 at t+10.
REQ-031 Same setup with loop=1 -> the write pattern repeats 1,2,3,1,... every 4 cycles; a stop write returns the FSM to IDLE next cycle with done=0.
REQ-032 Hold cpu_gpio_we_i=1 on the cycle the sequencer enters LOAD -> the CPU write passes through and the sequencer write slips exactly 1 cycle with the same value; later spacing is measured from the granted write.
REQ-033 DIV=0, LEN-1=7 -> 8 back-to-back writes of PAT0..PAT7 on consecutive cycles.
REQ-034 Start and stop in the same write -> stays IDLE; start while busy -> the sequence is unchanged.
REQ-035 Reset during WAIT -> busy=0 next cycle, no further sequencer writes, and all registers read 0.
